pico_bus_responder: RTL and testbench

FPGA-side responder for the Pico 8-bit parallel bus (active-low cs_n/wr_n/rd_n strobes, Pico is bus initiator). Pico writes are pushed into an RX FIFO that streams bytes into the SIMD/processing datapath. Pico reads are served from a TX FIFO that the datapath fills. The block exposes split data in/out/oe so the top level owns the tri-state on the pico_data pins.

---
 rtl/pico_bus_responder.sv | 176 +++++++++++++++++
 tb/tb_pico_bus_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pico_bus_responder.sv
// Pico 8-bit parallel bus responder: synchronises the async strobes, pushes Pico
// writes into an RX FIFO and serves Pico reads from a TX FIFO filled by the datapath.
module pico_bus_responder #(
  parameter int          DEPTH      = 16,
  parameter int          AW         = 4,
  parameter logic [7:0]  EMPTY_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic [7:0] pico_data_in,
  output logic [7:0] pico_data_out,
  output logic       pico_data_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rx_overflow,
  output logic       tx_underflow,
  output logic       proto_err,
  input  logic       err_clr
);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  logic       cs_s1_q, cs_s2_q, wr_s1_q, wr_s2_q, wr_s3_q, rd_s1_q, rd_s2_q, rd_s3_q;
  logic [7:0] data_s1_q, data_s2_q;

  logic [7:0] rx_mem_q [DEPTH];
  logic [7:0] rx_mem_d [DEPTH];
  logic [7:0] tx_mem_q [DEPTH];
  logic [7:0] tx_mem_d [DEPTH];
  logic [AW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d, tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;

  state_t     state_q, state_d;
  logic       oe_q, oe_d, had_data_q, had_data_d;
  logic [7:0] dout_q, dout_d;
  logic       rx_ovf_q, rx_ovf_d, tx_unf_q, tx_unf_d, proto_q, proto_d;

  logic       wr_rise_s, rd_fall_s, rd_rise_s, proto_s;
  logic       rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
  logic       rx_pop_s, rx_push_s, capture_s, ovf_set_s;
  logic       tx_pop_s, tx_push_s, rd_enter_s;
  logic [7:0] tx_head_s;

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  assign wr_rise_s  = wr_s2_q & ~wr_s3_q;
  assign rd_fall_s  = ~rd_s2_q & rd_s3_q;
  assign rd_rise_s  = rd_s2_q & ~rd_s3_q;
  assign proto_s    = ~cs_s2_q & ~wr_s2_q & ~rd_s2_q;

  assign rx_empty_s = (rx_wp_q == rx_rp_q);
  assign rx_full_s  = (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]) && (rx_wp_q[AW] != rx_rp_q[AW]);
  assign tx_empty_s = (tx_wp_q == tx_rp_q);
  assign tx_full_s  = (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]) && (tx_wp_q[AW] != tx_rp_q[AW]);
  assign tx_head_s  = tx_mem_q[tx_rp_q[AW-1:0]];

  assign rx_pop_s   = rx_ready & ~rx_empty_s;
  assign capture_s  = (state_q == IDLE) & wr_rise_s & ~cs_s2_q & rd_s2_q & ~proto_s;
  // A push into a full RX FIFO still lands when the consumer frees a slot this cycle.
  assign rx_push_s  = capture_s & (~rx_full_s | rx_pop_s);
  assign ovf_set_s  = capture_s & rx_full_s & ~rx_pop_s;

  assign rd_enter_s = (state_q == IDLE) & rd_fall_s & ~cs_s2_q & wr_s2_q & ~proto_s;
  assign tx_push_s  = tx_valid & ~tx_full_s;
  assign tx_pop_s   = (state_q == READ) & ~cs_s2_q & rd_rise_s & had_data_q & ~tx_empty_s;

  // Next-state logic for FIFOs, read FSM and sticky flags.
  always_comb begin
    rx_mem_d   = rx_mem_q;
    tx_mem_d   = tx_mem_q;
    state_d    = state_q;
    oe_d       = oe_q;
    dout_d     = dout_q;
    had_data_d = had_data_q;

    if (rx_push_s) begin
      rx_mem_d[rx_wp_q[AW-1:0]] = data_s2_q;
    end else begin
      rx_mem_d = rx_mem_q;
    end
    if (tx_push_s) begin
      tx_mem_d[tx_wp_q[AW-1:0]] = tx_data;
    end else begin
      tx_mem_d = tx_mem_q;
    end
    rx_wp_d = rx_push_s ? rx_wp_q + PTR_ONE : rx_wp_q;
    rx_rp_d = rx_pop_s  ? rx_rp_q + PTR_ONE : rx_rp_q;
    tx_wp_d = tx_push_s ? tx_wp_q + PTR_ONE : tx_wp_q;
    tx_rp_d = tx_pop_s  ? tx_rp_q + PTR_ONE : tx_rp_q;

    case (state_q)
      IDLE: begin
        if (rd_enter_s) begin
          state_d    = READ;
          oe_d       = 1'b1;
          had_data_d = ~tx_empty_s;
          dout_d     = tx_empty_s ? EMPTY_BYTE : tx_head_s;
        end else begin
          state_d    = IDLE;
        end
      end
      READ: begin
        // cs_n release aborts the read; it also wins over a coincident rd_n rise.
        if (cs_s2_q || rd_rise_s) begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end else begin
          state_d = READ;
        end
      end
      default: begin
        state_d = IDLE;
        oe_d    = 1'b0;
      end
    endcase

    rx_ovf_d = ovf_set_s | (rx_ovf_q & ~err_clr);
    tx_unf_d = (rd_enter_s & tx_empty_s) | (tx_unf_q & ~err_clr);
    proto_d  = proto_s | (proto_q & ~err_clr);
  end

  // Control state, synchronisers and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_s1_q    <= 1'b1;  cs_s2_q <= 1'b1;
      wr_s1_q    <= 1'b1;  wr_s2_q <= 1'b1;  wr_s3_q <= 1'b1;
      rd_s1_q    <= 1'b1;  rd_s2_q <= 1'b1;  rd_s3_q <= 1'b1;
      data_s1_q  <= 8'h00; data_s2_q <= 8'h00;
      rx_wp_q    <= '0;    rx_rp_q <= '0;
      tx_wp_q    <= '0;    tx_rp_q <= '0;
      state_q    <= IDLE;
      oe_q       <= 1'b0;
      dout_q     <= 8'h00;
      had_data_q <= 1'b0;
      rx_ovf_q   <= 1'b0;
      tx_unf_q   <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      cs_s1_q    <= cs_n;    cs_s2_q <= cs_s1_q;
      wr_s1_q    <= wr_n;    wr_s2_q <= wr_s1_q;  wr_s3_q <= wr_s2_q;
      rd_s1_q    <= rd_n;    rd_s2_q <= rd_s1_q;  rd_s3_q <= rd_s2_q;
      data_s1_q  <= pico_data_in;  data_s2_q <= data_s1_q;
      rx_wp_q    <= rx_wp_d; rx_rp_q <= rx_rp_d;
      tx_wp_q    <= tx_wp_d; tx_rp_q <= tx_rp_d;
      state_q    <= state_d;
      oe_q       <= oe_d;
      dout_q     <= dout_d;
      had_data_q <= had_data_d;
      rx_ovf_q   <= rx_ovf_d;
      tx_unf_q   <= tx_unf_d;
      proto_q    <= proto_d;
    end
  end

  // Storage arrays need no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    rx_mem_q <= rx_mem_d;
    tx_mem_q <= tx_mem_d;
  end

  assign pico_data_out = dout_q;
  assign pico_data_oe  = oe_q;
  assign rx_data       = rx_mem_q[rx_rp_q[AW-1:0]];
  assign rx_valid      = ~rx_empty_s;
  assign tx_ready      = ~tx_full_s;
  assign rx_overflow   = rx_ovf_q;
  assign tx_underflow  = tx_unf_q;
  assign proto_err     = proto_q;

endmodule

// File: tb/tb_pico_bus_responder.sv
// Self-checking bench for pico_bus_responder: Pico bus transactions and random
// traffic compared against a queue-based model of the two FIFOs and sticky flags.
module tb_pico_bus_responder;
  logic       clk = 1'b0;
  logic       rst, cs_n, wr_n, rd_n, rx_ready, tx_valid, err_clr;
  logic [7:0] pico_data_in, tx_data;
  logic [7:0] pico_data_out, rx_data;
  logic       pico_data_oe, rx_valid, tx_ready, rx_overflow, tx_underflow, proto_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       m_ovf, m_unf, m_proto;

  always #5 clk = ~clk;

  pico_bus_responder #(.DEPTH(16), .AW(4), .EMPTY_BYTE(8'h00)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
    .pico_data_in(pico_data_in), .pico_data_out(pico_data_out), .pico_data_oe(pico_data_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_overflow(rx_overflow), .tx_underflow(tx_underflow), .proto_err(proto_err),
    .err_clr(err_clr)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pico_write(input logic [7:0] b);
    @(negedge clk); pico_data_in = b; cs_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    wr_n = 1'b1;
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // lat/off are cycles from rd_n edge to oe change; 99 means never seen.
  task automatic pico_read(output logic [7:0] d, output int lat, output int off);
    d = 8'hXX; lat = 99; off = 99;
    @(negedge clk); cs_n = 1'b0; rd_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (pico_data_oe === 1'b1 && lat == 99) begin lat = i; d = pico_data_out; end
    end
    rd_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (pico_data_oe === 1'b0 && off == 99) off = i;
    end
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic producer_push(input logic [7:0] b, output logic rdy);
    @(negedge clk); tx_data = b; tx_valid = 1'b1; rdy = tx_ready;
    @(negedge clk); tx_valid = 1'b0;
  endtask

  task automatic consumer_pop(output logic v, output logic [7:0] d);
    @(negedge clk); v = rx_valid; d = rx_data; rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
  endtask

  task automatic clear_flags();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0; m_proto = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; rx_ready = 1'b0;
    tx_valid = 1'b0; err_clr = 1'b0; pico_data_in = 8'h00; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx_q.delete(); tx_q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_proto = 1'b0;
    @(negedge clk);
    checks++; if (pico_data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", pico_data_out); end
    checks++; if (pico_data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", pico_data_oe); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
    checks++; if ({rx_overflow, tx_underflow, proto_err} !== 3'b000) begin errors++;
      $display("FAIL reset_flags got %b want 000", {rx_overflow, tx_underflow, proto_err}); end
  endtask

  task automatic test_write_basic();
    logic v; logic [7:0] d;
    pico_write(8'hA5); pico_write(8'h3C);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL wr_valid got %b want 1", rx_valid); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL wr_head got %h want a5", rx_data); end
    consumer_pop(v, d);
    consumer_pop(v, d);
    checks++; if ({v, d} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL wr_second got %b/%h want 1/3c", v, d); end
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL wr_empty got %b want 0", rx_valid); end
    checks++; if ({rx_overflow, tx_underflow, proto_err} !== 3'b000) begin errors++;
      $display("FAIL wr_flags got %b want 000", {rx_overflow, tx_underflow, proto_err}); end
  endtask

  task automatic test_read_basic();
    logic rdy; logic [7:0] d; int lat, off;
    logic [7:0] vals [2];
    vals[0] = 8'h11; vals[1] = 8'h22;
    for (int i = 0; i < 2; i++) producer_push(vals[i], rdy);
    for (int i = 0; i < 2; i++) begin
      pico_read(d, lat, off);
      checks++; if (lat > 4) begin errors++; $display("FAIL rd_oe_latency got %0d want <=4", lat); end
      checks++; if (d !== vals[i]) begin errors++; $display("FAIL rd_data got %h want %h", d, vals[i]); end
      checks++; if (off > 5) begin errors++; $display("FAIL rd_oe_release got %0d want <=5", off); end
    end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rd_tx_ready got %b want 1", tx_ready); end
  endtask

  task automatic test_underflow();
    logic rdy; logic [7:0] d; int lat, off;
    pico_read(d, lat, off);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL unf_data got %h want 00", d); end
    repeat (5) @(negedge clk);
    checks++; if (tx_underflow !== 1'b1) begin errors++; $display("FAIL unf_sticky got %b want 1", tx_underflow); end
    clear_flags();
    checks++; if (tx_underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got %b want 0", tx_underflow); end
    producer_push(8'h77, rdy);
    pico_read(d, lat, off);
    checks++; if (d !== 8'h77) begin errors++; $display("FAIL unf_ptr_data got %h want 77", d); end
    checks++; if (tx_underflow !== 1'b0) begin errors++; $display("FAIL unf_ptr_flag got %b want 0", tx_underflow); end
  endtask

  task automatic test_overflow();
    logic v; logic [7:0] d;
    for (int i = 0; i < 17; i++) begin
      pico_write(8'(i));
      if (rx_q.size() < 16) rx_q.push_back(8'(i)); else m_ovf = 1'b1;
    end
    checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", rx_overflow); end
    consumer_pop(v, d);
    checks++; if ({v, d} !== {1'b1, 8'h00}) begin errors++; $display("FAIL ovf_first got %b/%h want 1/00", v, d); end
    void'(rx_q.pop_front());
    pico_write(8'h55); rx_q.push_back(8'h55);
    while (rx_q.size() > 0) begin
      consumer_pop(v, d);
      checks++; if ({v, d} !== {1'b1, rx_q[0]}) begin errors++; $display("FAIL ovf_drain got %b/%h want 1/%h", v, d, rx_q[0]); end
      void'(rx_q.pop_front());
    end
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", rx_valid); end
    clear_flags();
  endtask

  task automatic test_abort_proto();
    logic rdy; logic [7:0] d; int lat, off, seen;
    producer_push(8'hAA, rdy); producer_push(8'hBB, rdy);
    @(negedge clk); cs_n = 1'b0; rd_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 8 && seen == 0; i++) begin @(negedge clk); if (pico_data_oe === 1'b1) seen = 1; end
    checks++; if (seen != 1 || pico_data_out !== 8'hAA) begin errors++; $display("FAIL abort_data got %h oe_seen %0d want aa", pico_data_out, seen); end
    cs_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (pico_data_oe !== 1'b0) begin errors++; $display("FAIL abort_oe got %b want 0", pico_data_oe); end
    rd_n = 1'b1;
    repeat (4) @(negedge clk);
    pico_read(d, lat, off);
    checks++; if (d !== 8'hAA) begin errors++; $display("FAIL abort_repeat got %h want aa", d); end
    pico_read(d, lat, off);
    checks++; if (d !== 8'hBB) begin errors++; $display("FAIL abort_next got %h want bb", d); end
    @(negedge clk); pico_data_in = 8'hEE; cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0;
    repeat (5) @(negedge clk); wr_n = 1'b1;
    repeat (5) @(negedge clk); rd_n = 1'b1;
    repeat (5) @(negedge clk); cs_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_flag got %b want 1", proto_err); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL proto_no_push got %b want 0", rx_valid); end
    checks++; if (pico_data_oe !== 1'b0) begin errors++; $display("FAIL proto_no_read got %b want 0", pico_data_oe); end
    clear_flags();
  endtask

  task automatic test_random();
    logic rdy, v; logic [7:0] b, d, exp; int lat, off;
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          pico_write(b);
          if (rx_q.size() < 16) rx_q.push_back(b); else m_ovf = 1'b1;
        end
        1: begin
          exp = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
          if (tx_q.size() > 0) void'(tx_q.pop_front()); else m_unf = 1'b1;
          pico_read(d, lat, off);
          checks++; if (d !== exp) begin errors++; $display("FAIL rand_read got %h want %h", d, exp); end
        end
        2: begin
          producer_push(b, rdy);
          checks++; if (rdy !== (tx_q.size() < 16)) begin errors++; $display("FAIL rand_tx_ready got %b want %b", rdy, tx_q.size() < 16); end
          if (tx_q.size() < 16) tx_q.push_back(b);
        end
        default: begin
          consumer_pop(v, d);
          checks++; if (v !== (rx_q.size() > 0)) begin errors++; $display("FAIL rand_rx_valid got %b want %b", v, rx_q.size() > 0); end
          if (rx_q.size() > 0) begin
            checks++; if (d !== rx_q[0]) begin errors++; $display("FAIL rand_rx_data got %h want %h", d, rx_q[0]); end
            void'(rx_q.pop_front());
          end
        end
      endcase
    end
    checks++; if ({rx_overflow, tx_underflow, proto_err} !== {m_ovf, m_unf, m_proto}) begin errors++;
      $display("FAIL rand_flags got %b want %b", {rx_overflow, tx_underflow, proto_err}, {m_ovf, m_unf, m_proto}); end
    clear_flags();
  endtask

  task automatic test_reset_mid_read();
    logic rdy; int seen;
    for (int i = 0; i < 3; i++) begin pico_write(8'(8'h40 + i)); producer_push(8'(8'h50 + i), rdy); end
    @(negedge clk); cs_n = 1'b0; rd_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 8 && seen == 0; i++) begin @(negedge clk); if (pico_data_oe === 1'b1) seen = 1; end
    checks++; if (seen != 1) begin errors++; $display("FAIL rstrd_enter got oe %b want 1", pico_data_oe); end
    rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
    checks++; if (pico_data_oe !== 1'b0) begin errors++; $display("FAIL rstrd_oe got %b want 0", pico_data_oe); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstrd_rx_valid got %b want 0", rx_valid); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstrd_tx_ready got %b want 1", tx_ready); end
    checks++; if ({rx_overflow, tx_underflow, proto_err} !== 3'b000) begin errors++;
      $display("FAIL rstrd_flags got %b want 000", {rx_overflow, tx_underflow, proto_err}); end
    @(negedge clk); rst = 1'b0;
    rx_q.delete(); tx_q.delete();
    repeat (4) @(negedge clk);
    checks++; if ({pico_data_oe, rx_valid} !== 2'b00) begin errors++; $display("FAIL rstrd_after got %b want 00", {pico_data_oe, rx_valid}); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_underflow();
    test_overflow();
    test_abort_proto();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
